// File: rtl/mul_div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_div_pkg : opcodes, FSM states and latencies for mul_div_unit         |
// | Optional build macro: MULDIV_RADIX4_MUL_EN    Rev 1.0                    |
// +--------------------------------------------------------------------------+
package mul_div_pkg;

  localparam int DEF_WIDTH = 32;

  // Shared with the ALU decode.
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

`ifdef MULDIV_RADIX4_MUL_EN
  localparam bit RADIX4_MUL = 1'b1;
  localparam int LAT_MUL    = DEF_WIDTH / 2 + 1;
`else
  localparam bit RADIX4_MUL = 1'b0;
  localparam int LAT_MUL    = DEF_WIDTH + 1;
`endif

  // Cycles from the accept edge (cycle 0) to the first cycle with done high.
  localparam int LAT_DIV  = DEF_WIDTH + 2;
  localparam int LAT_DIV0 = 1;

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_booth_recoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | booth_recoder : Booth digit recoding into select / negate controls       |
// | Radix-2 takes {q0, q-1}; radix-4 takes {q1, q0, q-1}.   Rev 1.0          |
// +--------------------------------------------------------------------------+
module booth_recoder
  import mul_div_pkg::*;
#(
  parameter bit RADIX4 = 1'b0,
  parameter int BITS   = RADIX4 ? 3 : 2
) (
  input  logic [BITS-1:0] bits,
  output logic            sel_one,
  output logic            sel_two,
  output logic            neg
);

  generate
    if (RADIX4) begin : g_radix4
      always_comb begin
        sel_one = bits[1] ^ bits[0];
        sel_two = (bits == 3'b011) || (bits == 3'b100);
        neg     = bits[2] & ~(bits[1] & bits[0]);
      end
    end else begin : g_radix2
      always_comb begin
        sel_one = bits[1] ^ bits[0];
        sel_two = 1'b0;
        neg     = bits[1] & ~bits[0];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_div_unit : multi-cycle signed Booth multiply / restoring divide      |
// | MULDIV_RADIX4_MUL_EN selects radix-4 multiply.          Rev 1.0          |
// +--------------------------------------------------------------------------+
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ZHI,
  output logic [WIDTH-1:0] ZLO,
  output logic             div_by_zero
);

  localparam int c_cnt_w  = $clog2(WIDTH);
  localparam bit c_radix4 = RADIX4_MUL;
  localparam int c_step   = c_radix4 ? 2 : 1;
  localparam int c_bits   = c_radix4 ? 3 : 2;
  localparam logic [c_cnt_w-1:0] c_mul_last = c_cnt_w'(WIDTH / c_step - 1);
  localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_q;
  logic                 r_q1;
  logic [WIDTH+1:0]     r_acc;
  logic [WIDTH-1:0]     r_rem;
  logic                 r_sign_a;
  logic                 r_sign_b;
  logic [WIDTH-1:0]     r_zhi;
  logic [WIDTH-1:0]     r_zlo;
  logic                 r_dbz;

  logic                 w_op_valid;
  logic                 w_accept;
  logic                 w_rb_zero;

  assign w_op_valid = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign w_accept   = (r_state == IDLE) && start && w_op_valid;
  assign w_rb_zero  = (Rb == '0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (opcode == OP_MUL) w_state_nxt = MUL;
          else if (w_rb_zero)   w_state_nxt = DONE;
          else                  w_state_nxt = DIV;
        end
      end
      MUL:     if (r_cnt == '0) w_state_nxt = DONE;
      DIV:     if (r_cnt == '0) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == MUL) || (r_state == DIV) || (r_state == FIX);
    done = (r_state == DONE);
  end

  // ---------------------------------------------------------------- Booth multiply
  // Accumulator carries two guard bits so that A - M and A +/- 2M never overflow.
  logic [c_bits-1:0] w_booth_bits;
  logic              w_sel_one;
  logic              w_sel_two;
  logic              w_neg;
  logic [WIDTH+1:0]  w_m_ext;
  logic [WIDTH+1:0]  w_addend;
  logic [WIDTH+1:0]  w_sum;
  logic [WIDTH+1:0]  w_acc_nxt;
  logic [WIDTH-1:0]  w_q_nxt;
  logic              w_q1_nxt;

  generate
    if (c_radix4) begin : g_mul_r4
      assign w_booth_bits = {r_q[1:0], r_q1};
      assign w_acc_nxt    = {{2{w_sum[WIDTH+1]}}, w_sum[WIDTH+1:2]};
      assign w_q_nxt      = {w_sum[1:0], r_q[WIDTH-1:2]};
      assign w_q1_nxt     = r_q[1];
    end else begin : g_mul_r2
      assign w_booth_bits = {r_q[0], r_q1};
      assign w_acc_nxt    = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
      assign w_q_nxt      = {w_sum[0], r_q[WIDTH-1:1]};
      assign w_q1_nxt     = r_q[0];
    end
  endgenerate

  booth_recoder #(
    .RADIX4 (c_radix4),
    .BITS   (c_bits)
  ) u_booth_recoder (
    .bits    (w_booth_bits),
    .sel_one (w_sel_one),
    .sel_two (w_sel_two),
    .neg     (w_neg)
  );

  assign w_m_ext = {{2{r_m[WIDTH-1]}}, r_m};

  always_comb begin
    w_addend = '0;
    if (w_sel_two)      w_addend = {w_m_ext[WIDTH:0], 1'b0};
    else if (w_sel_one) w_addend = w_m_ext;
  end

  assign w_sum = w_neg ? (r_acc - w_addend) : (r_acc + w_addend);

  // ---------------------------------------------------------------- restoring divide
  // r_q holds the dividend magnitude and fills with quotient bits from the right.
  logic [WIDTH:0]   w_rsh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_ra_mag;
  logic [WIDTH-1:0] w_rb_mag;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_rsh     = {r_rem, r_q[WIDTH-1]};
  assign w_ge      = (w_rsh >= {1'b0, r_m});
  assign w_diff    = w_rsh[WIDTH-1:0] - r_m;
  assign w_rem_nxt = w_ge ? w_diff : w_rsh[WIDTH-1:0];
  assign w_ra_mag  = Ra[WIDTH-1] ? -Ra : Ra;
  assign w_rb_mag  = Rb[WIDTH-1] ? -Rb : Rb;
  assign w_quo_fix = (r_sign_a ^ r_sign_b) ? -r_q : r_q;
  assign w_rem_fix = r_sign_a ? -r_rem : r_rem;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_cnt    <= '0;
      r_m      <= '0;
      r_q      <= '0;
      r_q1     <= 1'b0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_zhi    <= '0;
      r_zlo    <= '0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dbz <= 1'b0;
            if (opcode == OP_MUL) begin
              r_m   <= Ra;
              r_q   <= Rb;
              r_q1  <= 1'b0;
              r_acc <= '0;
              r_cnt <= c_mul_last;
            end else if (w_rb_zero) begin
              r_zhi <= Ra;
              r_zlo <= '1;
              r_dbz <= 1'b1;
            end else begin
              r_m      <= w_rb_mag;
              r_q      <= w_ra_mag;
              r_rem    <= '0;
              r_sign_a <= Ra[WIDTH-1];
              r_sign_b <= Rb[WIDTH-1];
              r_cnt    <= c_div_last;
            end
          end
        end
        MUL: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_q1  <= w_q1_nxt;
          r_cnt <= r_cnt - c_one;
          if (r_cnt == '0) begin
            r_zhi <= w_acc_nxt[WIDTH-1:0];
            r_zlo <= w_q_nxt;
          end
        end
        DIV: begin
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - c_one;
        end
        FIX: begin
          r_zhi <= w_rem_fix;
          r_zlo <= w_quo_fix;
        end
        default: ;
      endcase
    end
  end

  assign ZHI         = r_zhi;
  assign ZLO         = r_zlo;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mul_div_unit : directed self-checking bench for mul_div_unit          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mul_div_unit;
  import mul_div_pkg::*;

  localparam int W = DEF_WIDTH;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic [4:0]   opcode;
  logic [W-1:0] Ra;
  logic [W-1:0] Rb;
  logic         busy;
  logic         done;
  logic [W-1:0] ZHI;
  logic [W-1:0] ZLO;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mul_div_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .opcode      (opcode),
    .Ra          (Ra),
    .Rb          (Rb),
    .busy        (busy),
    .done        (done),
    .ZHI         (ZHI),
    .ZLO         (ZLO),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one operation and measures the cycle on which done first appears.
  // inj_cyc != 0 drives a conflicting start pulse during that busy cycle.
  task automatic run_op(input string tag, input logic [4:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic exp_dbz,
                        input int inj_cyc);
    int cyc;
    @(negedge clock);
    start = 1'b1; opcode = op; Ra = a; Rb = b;
    @(posedge clock); #1;
    start = 1'b0; opcode = OP_DIV; Ra = 32'h5A5A_1234; Rb = 32'h0000_0003;
    cyc = 1;
    while (!done && cyc < 200) begin
      if (cyc == 1) check({tag, " busy"}, busy, 1'b1);
      if (inj_cyc != 0 && cyc == inj_cyc) begin
        start = 1'b1; opcode = OP_MUL; Ra = 32'd3; Rb = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " busy@done"}, busy, 1'b0);
    check({tag, " ZHI"}, ZHI, exp_hi);
    check({tag, " ZLO"}, ZLO, exp_lo);
    check({tag, " dbz"}, div_by_zero, exp_dbz);
    @(posedge clock); #1;
    check({tag, " done pulse"}, done, 1'b0);
    check({tag, " ZHI hold"}, ZHI, exp_hi);
    check({tag, " ZLO hold"}, ZLO, exp_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int saw_done;
    clear = 1'b1; start = 1'b0; opcode = '0; Ra = '0; Rb = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst ZHI", ZHI, '0);
    check("rst ZLO", ZLO, '0);
    check("rst dbz", div_by_zero, 1'b0);
    @(negedge clock);
    clear = 1'b0;

    // Conflicting start at busy cycle 5 must be ignored.
    run_op("mul 7*-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, LAT_MUL,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 5);

    // Unsupported opcode in IDLE: no activity, outputs hold.
    @(negedge clock);
    start = 1'b1; opcode = 5'b00011; Ra = 32'd9; Rb = 32'd9;
    @(posedge clock); #1;
    start = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) saw_done++;
      @(posedge clock); #1;
    end
    check("bad op activity", saw_done, 0);
    check("bad op ZHI", ZHI, 32'hFFFF_FFFF);
    check("bad op ZLO", ZLO, 32'hFFFF_FFEB);

    run_op("mul minneg^2", OP_MUL, 32'h8000_0000, 32'h8000_0000, LAT_MUL,
           32'h4000_0000, 32'h0000_0000, 1'b0, 0);
    run_op("mul maxpos^2", OP_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, LAT_MUL,
           32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op("mul -1*-1", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MUL,
           32'h0000_0000, 32'h0000_0001, 1'b0, 0);
    run_op("mul minneg*1", OP_MUL, 32'h8000_0000, 32'h0000_0001, LAT_MUL,
           32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
    run_op("div -17/5", OP_DIV, 32'hFFFF_FFEF, 32'd5, LAT_DIV,
           32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("div 17/-5", OP_DIV, 32'd17, 32'hFFFF_FFFB, LAT_DIV,
           32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("div minneg/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, LAT_DIV,
           32'h0000_0000, 32'h8000_0000, 1'b0, 0);
    run_op("div 100/0", OP_DIV, 32'd100, 32'd0, LAT_DIV0,
           32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("div 100/7", OP_DIV, 32'd100, 32'd7, LAT_DIV,
           32'h0000_0002, 32'h0000_000E, 1'b0, 0);

    // Asynchronous clear at cycle 10 of a divide.
    @(negedge clock);
    start = 1'b1; opcode = OP_DIV; Ra = 32'd1000; Rb = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #2 clear = 1'b1;
    #1;
    check("clr busy", busy, 1'b0);
    check("clr done", done, 1'b0);
    check("clr ZHI", ZHI, '0);
    check("clr ZLO", ZLO, '0);
    check("clr dbz", div_by_zero, 1'b0);
    @(negedge clock);
    clear = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done || busy) saw_done++;
    end
    check("clr aborted", saw_done, 0);

    run_op("mul 6*7", OP_MUL, 32'd6, 32'd7, LAT_MUL,
           32'h0000_0000, 32'h0000_002A, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle signed multiply/divide engine upstream of the ALU result path; supplies the 64-bit ZHI/ZLO pair for the Multiply (5'b01110) and Divide (5'b01111) opcodes.
- The control unit pulses start, waits for done, then latches ZHI/ZLO into the Z register pair like any other ALU result.
- Radix-2 Booth multiply; restoring divide on magnitudes with a sign fix-up cycle.

Parameters:
- WIDTH, 32, operand width; results are 2*WIDTH total (ZHI:ZLO).

Ports:
- clock  in  1  system clock; all state on rising edge
- clear  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- opcode  in  5  5'b01110 Multiply, 5'b01111 Divide; other values make start a no-op
- Ra  in  WIDTH  multiplicand / dividend, sampled on the accepted start edge
- Rb  in  WIDTH  multiplier / divisor, sampled on the accepted start edge
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  single-cycle pulse; ZHI/ZLO are valid from this cycle on
- ZHI  out  WIDTH  product high word / remainder
- ZLO  out  WIDTH  product low word / quotient
- div_by_zero  out  1  set with done when Divide had Rb==0; cleared on next accepted start

Behaviour:
- Reset: state=IDLE; busy, done, div_by_zero=0; ZHI=ZLO=0. Asynchronous clear mid-operation aborts immediately, drops the partial result, and forces the same values.
- Accept: in IDLE with start=1 and a valid opcode, Ra/Rb are captured internally. Later input changes have no effect.
- Start while busy or in DONE: ignored; no queueing.
- Start with any other opcode: ignored; outputs unchanged.
- States: IDLE -> MUL (WIDTH cycles) -> DONE -> IDLE.
- States: IDLE -> DIV (WIDTH cycles) -> FIX -> DONE -> IDLE.
- States: IDLE -> DONE on divide-by-zero.
- Multiply: accumulator {A, Q, q-1}. Each cycle, add or subtract M per the pair {Q[0], q-1}, then arithmetic-shift right 1. Counter runs WIDTH-1 down to 0.
- Multiply result: exact signed 2*WIDTH product; ZHI = upper word, ZLO = lower word.
- Divide: at acceptance, take |Ra| and |Rb| and record both signs. Each DIV cycle: shift {R,Q} left, trial-subtract |Rb|; if non-negative, keep it and set Q[0]=1.
- FIX cycle: quotient is negated if the signs differ. Remainder takes the dividend's sign (truncating division). Outputs ZLO=quotient, ZHI=remainder.
- Most-negative operands: 0x80000000 / 0xFFFFFFFF gives ZLO=0x80000000, ZHI=0 (wrap, no flag).
- Divide by zero: the next cycle is DONE with ZLO=all-ones, ZHI=Ra, div_by_zero=1.
- Latency, counting the accept edge as cycle 0: Multiply done at cycle WIDTH+1 (33); Divide done at cycle WIDTH+2 (34); divide-by-zero done at cycle 1.
- ZHI/ZLO update only in the DONE transition and hold until the next completion or clear. Intermediate values never appear on the outputs.
- busy and done are never high together; done is high for exactly one cycle.

Optional Feature:
- Macro: MULDIV_RADIX4_MUL_EN.
- Defined: Multiply uses radix-4 Booth. Each cycle recodes 3 bits into {0, ±M, ±2M} and shifts 2, for WIDTH/2 cycles. Done at cycle WIDTH/2+1 (17). Results are identical.
- Undefined: radix-2 as above.
- Divide behaviour is identical either way.

Decomposition:
- Package mul_div_pkg: opcode constants OP_MUL=5'b01110 and OP_DIV=5'b01111 (shared with the ALU decode), state enum {IDLE, MUL, DIV, FIX, DONE}, default WIDTH, and latency constants for bench checking.
- Sub-module booth_recoder: combinational; takes 2 bits (radix-2) or 3 bits (radix-4) and produces select/negate controls.
- The divide datapath stays inline.

Test Plan:
- Multiply Ra=7, Rb=-3 (0xFFFFFFFD) -> done at cycle 33 (17 with radix-4), ZHI=0xFFFFFFFF, ZLO=0xFFFFFFEB.
- Multiply 0x80000000 * 0x80000000 -> ZHI=0x40000000, ZLO=0x00000000.
- Divide Ra=-17, Rb=5 -> done at cycle 34, ZLO=0xFFFFFFFD, ZHI=0xFFFFFFFE, div_by_zero=0.
- Divide Ra=100, Rb=0 -> done at cycle 1, ZLO=0xFFFFFFFF, ZHI=0x00000064, div_by_zero=1.
- Start pulse while busy with different Ra/Rb, and start with opcode 5'b00011 in IDLE -> both ignored; first result unchanged; no extra done.
- Assert clear at cycle 10 of a Divide -> outputs 0, state IDLE at once. A new Multiply 6*7 then gives ZLO=42, ZHI=0.
